snow_v_stream_ctrl: RTL
=======================

Name: snow_v_stream_ctrl

Overview:
Parametrised session controller around the SNOW_V keystream core. It accepts a key/IV pair with a block count and mode via a valid/ready handshake, then loads the core. It runs the init phase and discards that output. It then streams the requested number of keystream blocks, or keystream XOR input data, under downstream backpressure. The core advances only when a block is consumed.

Parameters:
KEY_W, 256, key width (core s_key)
IV_W, 128, IV width (core IV)
WORD_W, 128, keystream/data word width
INIT_CYCLES, 16, enabled core cycles discarded after load
CNT_W, 16, width of the block-count field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
start_valid  in  1  session request valid
start_ready  out  1  controller can accept a session
s_key  in  KEY_W  session key, sampled on start handshake
IV  in  IV_W  session IV, sampled on start handshake
num_blocks  in  CNT_W  blocks to emit, sampled on start handshake
xor_en  in  1  0 = raw keystream, 1 = dout = keystream ^ din; sampled on start handshake
abort  in  1  terminate current session
din_valid  in  1  input data valid (used only when xor_en latched 1)
din_ready  out  1  input data accepted
din  in  WORD_W  plaintext/ciphertext word
dout_valid  out  1  output word valid
dout_ready  in  1  downstream accepts
dout  out  WORD_W  output word
dout_last  out  1  marks final block of the session
busy  out  1  state != IDLE
core_load  out  1  core loads core_key/core_iv on this enabled edge
core_en  out  1  core advances one step on this edge
core_key  out  KEY_W  latched key
core_iv  out  IV_W  latched IV
core_keystream  in  WORD_W  current core output word

Behaviour:
- Core contract: core acts only on edges with core_en=1. With core_load=1 it loads key/IV. core_keystream is valid for the current state and changes only after an enabled edge.
- Reset (rst_n=0 at a clk edge, from any state): state IDLE; counters 0; key/IV/mode registers 0. All outputs 0 except start_ready=1.
- FSM states: IDLE, LOAD, INIT, STREAM.
- IDLE: start_ready=1. On start_valid&start_ready, latch s_key, IV, num_blocks, xor_en.
  - num_blocks==0: remain IDLE. No core activity, no output.
  - otherwise: go to LOAD.
- LOAD: exactly 1 cycle. core_load=1, core_en=1. Next state INIT; init counter set to INIT_CYCLES-1.
- INIT: core_en=1 every cycle for INIT_CYCLES cycles. dout_valid=0. Counter decrements; at 0 go to STREAM.
- Latency: start accepted in cycle T → LOAD in T+1 → INIT in T+2..T+1+INIT_CYCLES → first dout_valid possible in T+2+INIT_CYCLES (T+18 by default).
- STREAM handshake, all combinational, zero latency:
  - xor_en=0: dout_valid=1; dout=core_keystream; din_ready=0.
  - xor_en=1: dout_valid=din_valid; dout=core_keystream^din; din_ready=dout_ready.
  - transfer = dout_valid&dout_ready; core_en=transfer.
  - dout_last=1 when blocks_left==1.
  - Each transfer decrements blocks_left. The transfer with dout_last=1 returns to IDLE; start_ready=1 the next cycle.
- Backpressure: while dout_ready=0, core_en=0 and dout is held stable; no keystream word is skipped or duplicated.
- abort=1 in any non-IDLE state: next state IDLE. The cycle's outputs are forced as dout_valid=0, din_ready=0, core_en=0, core_load=0; no transfer occurs. abort in IDLE is ignored.
- start_valid outside IDLE is ignored (start_ready=0).
- Simultaneous rst_n=0 and abort: reset wins.
- busy=1 in LOAD, INIT and STREAM.
- dout=0 and dout_last=0 whenever dout_valid=0.
- blocks_left wraps never: num_blocks=2^CNT_W-1 streams that many blocks exactly.

Test Plan:
- Basic session: s_key=256'h0f33b29436c2bd4f92e798f2ed0824f19b15acd9aacf80d8f3f46eea61237fc9, IV=128'h122052e9c61e2e7e45208419998a007c, num_blocks=4, xor_en=0, dout_ready=1, start at T. Required: core_load=1 only at T+1; dout_valid from T+18 to T+21; dout matches the golden model's first 4 post-init keystream words; dout_last only at T+21; start_ready=1 at T+22.
- Backpressure: same session with dout_ready low for 5 cycles after the first word. Required: core_en=0 and dout stable for those 5 cycles; all 4 words identical to the basic run.
- XOR mode: xor_en=1, num_blocks=2. din=0 → dout equals the keystream. din=128'hFFFF…FF → dout equals ~keystream. din_valid=0 for 3 cycles → dout_valid=0 and core_en=0 for those cycles.
- Zero count: num_blocks=0. Required: start accepted, busy stays 0, core_load/core_en never assert, start_ready stays 1.
- Reset mid-INIT: rst_n=0 at T+8 for 1 cycle. Required: all outputs 0 except start_ready=1. A new session afterwards reproduces the basic-run words.
- Abort in STREAM: abort=1 after 2 of 4 words. Required: no further dout_valid, state IDLE next cycle. A restarted session yields the same first words as the basic run.

Source files
------------

// File: rtl/snow_v_stream_ctrl.sv
// Session controller for the SNOW_V keystream core: load, discard init output,
// then stream keystream (or keystream ^ din) one block per consumed transfer.
module snow_v_stream_ctrl #(
  parameter int unsigned KEY_W       = 256,
  parameter int unsigned IV_W        = 128,
  parameter int unsigned WORD_W      = 128,
  parameter int unsigned INIT_CYCLES = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [KEY_W-1:0]  s_key,
  input  logic [IV_W-1:0]   IV,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic              xor_en,
  input  logic              abort,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [WORD_W-1:0] din,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [WORD_W-1:0] dout,
  output logic              dout_last,
  output logic              busy,
  output logic              core_load,
  output logic              core_en,
  output logic [KEY_W-1:0]  core_key,
  output logic [IV_W-1:0]   core_iv,
  input  logic [WORD_W-1:0] core_keystream
);

  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    INIT   = 2'd2,
    STREAM = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]   blocks_q, blocks_d;
  logic [KEY_W-1:0]   key_q;
  logic [IV_W-1:0]    iv_q;
  logic               xor_q;
  logic               start_fire;
  logic               transfer;
  logic               last_blk;

  // State and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      init_cnt_q <= '0;
      blocks_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      blocks_q   <= blocks_d;
    end
  end

  // Session parameters captured on the start handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
      iv_q  <= '0;
      xor_q <= 1'b0;
    end else if (start_fire) begin
      key_q <= s_key;
      iv_q  <= IV;
      xor_q <= xor_en;
    end
  end

  assign core_key = key_q;
  assign core_iv  = iv_q;

  // Next state and zero-latency handshake outputs; abort masks all activity
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    blocks_d    = blocks_q;
    start_ready = 1'b0;
    busy        = 1'b1;
    core_load   = 1'b0;
    core_en     = 1'b0;
    dout_valid  = 1'b0;
    din_ready   = 1'b0;
    dout        = '0;
    dout_last   = 1'b0;
    start_fire  = 1'b0;
    transfer    = 1'b0;
    last_blk    = (blocks_q == CNT_W'(1));

    case (state_q)
      IDLE: begin
        busy        = 1'b0;
        start_ready = 1'b1;
        start_fire  = start_valid;
        if (start_valid) begin
          blocks_d = num_blocks;
          if (num_blocks != '0) state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          core_load  = 1'b1;
          core_en    = 1'b1;
          init_cnt_d = INIT_LAST;
          state_d    = INIT;
        end
      end
      INIT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          core_en = 1'b1;
          if (init_cnt_q == '0) state_d = STREAM;
          else init_cnt_d = init_cnt_q - INIT_W'(1);
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          dout_valid = xor_q ? din_valid : 1'b1;
          din_ready  = xor_q & dout_ready;
          transfer   = dout_valid & dout_ready;
          core_en    = transfer;
          if (dout_valid) begin
            dout      = core_keystream ^ (xor_q ? din : '0);
            dout_last = last_blk;
          end
          if (transfer) begin
            blocks_d = blocks_q - CNT_W'(1);
            if (last_blk) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
